enc_mpp: RTL and testbench
==========================

// Module: enc_mpp
// PURPOSE
//  Encoder-side midpoint-prediction (MPP) path; inverse of the decoder MPP reconstruction.
//  Takes one 16-sample block per component (c0 BPC bits unsigned; c1/c2 BPC+1 bits two's complement).
//  Computes the midpoint, the quantised residuals and the reconstruction.
//  Packs the residuals into the 4 substream (ssm) lanes consumed by the entropy coder.
//  Returns the reconstruction for the next block's midpoint and for the rate controller.
// PARAMETERS
//  BPC  8  component-0 bit depth; c1/c2 use BPC+1
// PORTS
//  clk          in   1           clock
//  rst          in   1           asynchronous, active-high reset
//  in_vld       in   1           block present on src/prev_rec/step/isFls
//  in_rdy       out  1           block accepted when in_vld&in_rdy
//  isFls        in   1           block is in first line of slice (no neighbour)
//  mpp_step     in   4           quantiser step (shift), 0..BPC-1
//  src_c0/1/2   in   [BPC(+1)-1:0] x16  source samples
//  prev_rec_c0/1/2 in [BPC(+1)-1:0] x16 neighbour reconstructed samples
//  out_vld      out  1           results valid
//  out_rdy      in   1           downstream accepts when out_vld&out_rdy
//  mpp_qres_ssm0..3 out [7:0] x16 packed signed quantised residuals
//  rec_c0/1/2   out  [BPC(+1)-1:0] x16  reconstruction
//  blkcounter   out  16          blocks accepted since reset
// BEHAVIOUR
//  - 3-stage pipeline, latency 3 cycles accept->out_vld.
//    S1: midpoint. S2: residual+quantise. S3: reconstruct+pack.
//  - Global advance en = ~out_vld | out_rdy.
//    in_rdy = en; all stage regs and valids move only when en.
//    A stall freezes every stage, outputs held stable.
//  - Midpoint MP:
//    - isFls=1: c0 MP=1<<(BPC-1); c1/c2 MP=0.
//    - else: MP = (sum(prev_rec 16) + 8) >>> 4; arithmetic shift for c1/c2.
//  - Residual: r = src - MP, width depth+1 signed.
//  - Quantise:
//    - q = sign(r) * ((|r| + rnd) >> step), with rnd = step ? 1<<(step-1) : 0.
//    - Clamp q to [-(1<<(depth-step-1)), (1<<(depth-step-1))-1].
//    - Then clamp to [-128,127].
//  - Reconstruct: rec = MP + (q << step), clipped to the component range.
//    Range is c0 [0,2^BPC-1]; c1/c2 [-2^BPC, 2^BPC-1].
//  - Packing (i=0..3): ssm0[i]=q0[i], ssm0[i+4]=q1[i], ssm0[i+8]=q2[i], ssm0[12..15]=0.
//  - Packing (j=4..15): ssm1[j-4]=q0[j], ssm2[j-4]=q1[j], ssm3[j-4]=q2[j]; ssm1..3[12..15]=0.
//  - blkcounter: +1 on each accept; wraps 0xFFFF->0.
//  - Reset (any cycle, incl. mid-pipeline):
//    - All valids=0, in-flight blocks discarded.
//    - ssm/rec outputs=0, blkcounter=0.
//    - in_rdy=1 the cycle after rst deasserts.
//  - Simultaneous accept and output handshake in one cycle is allowed at full throughput (1 block/cycle).
//  - mpp_step >= depth is illegal; S2 saturates step to depth-1.
// STRUCTURE
//  - enc_mpp_pkg holds the constants:
//    - MPP_BLK_SAMPLES=16, MPP_SSM_LANES=16, NUM_SSM=4, QRES_W=8.
//    - Midpoint defaults and the ssm0 lane offsets 0/4/8.
//  - Sub-module enc_mpp_com #(depth,k) implements the S1-S3 datapath for one component.
//    k=1 selects the signed chroma path.
//    Instantiated 3x (c0: BPC,k0; c1/c2: BPC+1,k1).
//  - Top level owns the handshake, the valid pipeline, blkcounter and ssm packing.
// TESTING
//  - BPC=8, isFls=1, src_c0=200 all, step=2.
//    -> MP=128, q=18, ssm1[0..11]=18, ssm0[0..3]=18, rec_c0=200, out_vld 3 cycles after accept.
//  - isFls=1, src_c0=0, step=3.
//    -> q=-16 (clamp edge -16), rec_c0=0; src_c0=255, step=0 -> q=127, rec=255.
//  - isFls=1, src_c1=-256, step=0.
//    -> q clamped to -128, rec_c1=-128; src_c2=255 -> q=127, rec=127.
//  - isFls=0, prev_rec_c0=100 all, src_c0=100, step=1.
//    -> MP=100, q=0, rec=100; prev_rec_c1 all -3 -> MP=-3.
//  - 4 back-to-back blocks, out_rdy=0 for 5 cycles from cycle 4.
//    -> in_rdy=0 while stalled, outputs stable, all 4 blocks emitted in order, blkcounter=4.
//  - rst pulsed while 2 blocks are in flight.
//    -> out_vld=0, outputs=0, blkcounter=0, no stale block emitted afterwards.

Source files
------------

// File: rtl/enc_mpp_pkg.sv
// Constants and helpers shared by the encoder midpoint-prediction path.
package enc_mpp_pkg;

    localparam int unsigned MPP_BLK_SAMPLES = 16;
    localparam int unsigned MPP_SSM_LANES   = 16;
    localparam int unsigned NUM_SSM         = 4;
    localparam int unsigned QRES_W          = 8;

    // Samples 0..3 of every component share ssm0; samples 4..15 get their own lane.
    localparam int unsigned SSM0_PER_COMP = 4;
    localparam int unsigned SSM0_OFF_C0   = 0;
    localparam int unsigned SSM0_OFF_C1   = 4;
    localparam int unsigned SSM0_OFF_C2   = 8;

    localparam int MPP_MP_CHROMA = 0;

    typedef logic [MPP_SSM_LANES-1:0][QRES_W-1:0] ssm_t;

    // Midpoint used when the block has no neighbour above it.
    function automatic int mp_default(int depth, bit chroma);
        return chroma ? MPP_MP_CHROMA : (1 << (depth - 1));
    endfunction

endpackage

// File: rtl/enc_mpp_com.sv
// Per-component MPP datapath: S1 midpoint, S2 residual+quantise, S3 reconstruct.
module enc_mpp_com
    import enc_mpp_pkg::*;
#(
    parameter int unsigned depth = 8,
    parameter bit          k     = 1'b0
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   en,
    input  logic                                   is_fls,
    input  logic [3:0]                             step,
    input  logic [MPP_BLK_SAMPLES-1:0][depth-1:0]  src,
    input  logic [MPP_BLK_SAMPLES-1:0][depth-1:0]  prev_rec,
    output logic [MPP_BLK_SAMPLES-1:0][QRES_W-1:0] qres,
    output logic [MPP_BLK_SAMPLES-1:0][depth-1:0]  rec
);

    // Wide enough for the 16-sample sum and every intermediate without overflow.
    localparam int unsigned W = depth + 6;
    localparam int unsigned N = MPP_BLK_SAMPLES;

    localparam logic [depth-1:0]    MP_FLS   = depth'(mp_default(depth, k));
    localparam logic [3:0]          STEP_MAX = 4'(depth - 1);
    localparam int                  REC_LO_I = k ? -(1 << (depth - 1)) : 0;
    localparam int                  REC_HI_I = k ? (1 << (depth - 1)) - 1 : (1 << depth) - 1;
    localparam logic signed [W-1:0] REC_LO   = W'(REC_LO_I);
    localparam logic signed [W-1:0] REC_HI   = W'(REC_HI_I);
    localparam logic signed [W-1:0] QMAX     = W'(127);
    localparam logic signed [W-1:0] QMIN     = W'(-128);

    function automatic logic signed [W-1:0] ext(input logic [depth-1:0] s);
        if (k) return W'(signed'(s));
        else   return W'(s);
    endfunction

    logic signed [W-1:0]         sum;
    logic [depth-1:0]            mp_d, mp1_q, mp2_q;
    logic [N-1:0][depth-1:0]     src1_q;
    logic [3:0]                  step1_q, step2_q, step_sat;
    logic signed [W-1:0]         rnd, lim;
    logic [N-1:0][QRES_W-1:0]    q2_d, q2_q, q3_q;
    logic [N-1:0][depth-1:0]     rec_d, rec_q;

    // S1: midpoint from the neighbour row, rounded and arithmetically shifted.
    always_comb begin
        sum = '0;
        for (int i = 0; i < N; i++) begin
            sum = sum + ext(prev_rec[i]);
        end
        mp_d = is_fls ? MP_FLS : depth'((sum + W'(8)) >>> 4);
    end

    // S2: step is saturated so an illegal step still yields a bounded result.
    always_comb begin
        step_sat = (step1_q > STEP_MAX) ? STEP_MAX : step1_q;
        rnd      = (step_sat == 4'd0) ? '0 : (W'(1) << (step_sat - 4'd1));
        lim      = W'(1) << (STEP_MAX - step_sat);
    end

    for (genvar i = 0; i < N; i++) begin : g_s2
        logic signed [W-1:0] r, mag, qm, qs;
        always_comb begin
            r   = ext(src1_q[i]) - ext(mp1_q);
            mag = r[W-1] ? -r : r;
            qm  = (mag + rnd) >> step_sat;
            qs  = r[W-1] ? -qm : qm;
            if (qs > lim - W'(1)) qs = lim - W'(1);
            if (qs < -lim)        qs = -lim;
            if (qs > QMAX)        qs = QMAX;
            if (qs < QMIN)        qs = QMIN;
        end
        assign q2_d[i] = QRES_W'(qs);
    end

    // S3: dequantise and clip to the component range.
    for (genvar i = 0; i < N; i++) begin : g_s3
        logic signed [W-1:0] rv;
        always_comb begin
            rv = ext(mp2_q) + (W'(signed'(q2_q[i])) <<< step2_q);
            if (rv < REC_LO) rv = REC_LO;
            if (rv > REC_HI) rv = REC_HI;
        end
        assign rec_d[i] = depth'(rv);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mp1_q   <= '0;
            src1_q  <= '0;
            step1_q <= '0;
            mp2_q   <= '0;
            q2_q    <= '0;
            step2_q <= '0;
            q3_q    <= '0;
            rec_q   <= '0;
        end else if (en) begin
            mp1_q   <= mp_d;
            src1_q  <= src;
            step1_q <= step;
            mp2_q   <= mp1_q;
            q2_q    <= q2_d;
            step2_q <= step_sat;
            q3_q    <= q2_q;
            rec_q   <= rec_d;
        end
    end

    assign qres = q3_q;
    assign rec  = rec_q;

endmodule

// File: rtl/enc_mpp.sv
// Encoder MPP top: handshake, valid pipeline, block counter and substream packing.
module enc_mpp
    import enc_mpp_pkg::*;
#(
    parameter int unsigned BPC = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_vld,
    output logic                                 in_rdy,
    input  logic                                 isFls,
    input  logic [3:0]                           mpp_step,
    input  logic [MPP_BLK_SAMPLES-1:0][BPC-1:0]  src_c0,
    input  logic [MPP_BLK_SAMPLES-1:0][BPC:0]    src_c1,
    input  logic [MPP_BLK_SAMPLES-1:0][BPC:0]    src_c2,
    input  logic [MPP_BLK_SAMPLES-1:0][BPC-1:0]  prev_rec_c0,
    input  logic [MPP_BLK_SAMPLES-1:0][BPC:0]    prev_rec_c1,
    input  logic [MPP_BLK_SAMPLES-1:0][BPC:0]    prev_rec_c2,
    output logic                                 out_vld,
    input  logic                                 out_rdy,
    output ssm_t                                 mpp_qres_ssm0,
    output ssm_t                                 mpp_qres_ssm1,
    output ssm_t                                 mpp_qres_ssm2,
    output ssm_t                                 mpp_qres_ssm3,
    output logic [MPP_BLK_SAMPLES-1:0][BPC-1:0]  rec_c0,
    output logic [MPP_BLK_SAMPLES-1:0][BPC:0]    rec_c1,
    output logic [MPP_BLK_SAMPLES-1:0][BPC:0]    rec_c2,
    output logic [15:0]                          blkcounter
);

    logic                                    en, accept;
    logic [2:0]                              vld_q;
    logic [15:0]                             blkcounter_q;
    logic [MPP_BLK_SAMPLES-1:0][QRES_W-1:0]  q_c0, q_c1, q_c2;

    // One global enable: a stalled output freezes the whole pipe.
    assign en      = ~out_vld | out_rdy;
    assign in_rdy  = en;
    assign accept  = in_vld & en;
    assign out_vld = vld_q[2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q        <= '0;
            blkcounter_q <= '0;
        end else begin
            if (en)     vld_q        <= {vld_q[1:0], in_vld};
            if (accept) blkcounter_q <= blkcounter_q + 16'd1;
        end
    end

    assign blkcounter = blkcounter_q;

    enc_mpp_com #(.depth(BPC), .k(1'b0)) u_com_c0 (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .is_fls   (isFls),
        .step     (mpp_step),
        .src      (src_c0),
        .prev_rec (prev_rec_c0),
        .qres     (q_c0),
        .rec      (rec_c0)
    );

    enc_mpp_com #(.depth(BPC + 1), .k(1'b1)) u_com_c1 (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .is_fls   (isFls),
        .step     (mpp_step),
        .src      (src_c1),
        .prev_rec (prev_rec_c1),
        .qres     (q_c1),
        .rec      (rec_c1)
    );

    enc_mpp_com #(.depth(BPC + 1), .k(1'b1)) u_com_c2 (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .is_fls   (isFls),
        .step     (mpp_step),
        .src      (src_c2),
        .prev_rec (prev_rec_c2),
        .qres     (q_c2),
        .rec      (rec_c2)
    );

    always_comb begin
        mpp_qres_ssm0 = '0;
        mpp_qres_ssm1 = '0;
        mpp_qres_ssm2 = '0;
        mpp_qres_ssm3 = '0;
        for (int i = 0; i < SSM0_PER_COMP; i++) begin
            mpp_qres_ssm0[SSM0_OFF_C0 + i] = q_c0[i];
            mpp_qres_ssm0[SSM0_OFF_C1 + i] = q_c1[i];
            mpp_qres_ssm0[SSM0_OFF_C2 + i] = q_c2[i];
        end
        for (int j = SSM0_PER_COMP; j < MPP_BLK_SAMPLES; j++) begin
            mpp_qres_ssm1[j - SSM0_PER_COMP] = q_c0[j];
            mpp_qres_ssm2[j - SSM0_PER_COMP] = q_c1[j];
            mpp_qres_ssm3[j - SSM0_PER_COMP] = q_c2[j];
        end
    end

endmodule

// File: tb/tb_enc_mpp.sv
// Scoreboard bench for enc_mpp: directed blocks, stall, and mid-flight reset.
module tb_enc_mpp;
    import enc_mpp_pkg::*;

    localparam int unsigned BPC = 8;
    localparam int N = 16;

    logic clk = 1'b0;
    logic rst, in_vld, in_rdy, isFls, out_vld, out_rdy;
    logic [3:0] mpp_step;
    logic [N-1:0][BPC-1:0] src_c0, prev_rec_c0, rec_c0;
    logic [N-1:0][BPC:0]   src_c1, src_c2, prev_rec_c1, prev_rec_c2, rec_c1, rec_c2;
    ssm_t ssm0, ssm1, ssm2, ssm3;
    logic [15:0] blkcounter;

    typedef struct packed {
        logic [N-1:0][7:0]     s0, s1, s2, s3;
        logic [N-1:0][BPC-1:0] r0;
        logic [N-1:0][BPC:0]   r1, r2;
    } exp_t;

    // ramp=1: src c0/c2 get +4*i and c1 gets -4*i; expected q moves by +/-i, rec by +/-4*i.
    typedef struct {
        int ramp, fls, step;
        int s0, s1, s2;
        int p0, p1, p2;
        int q0, q1, q2;
        int r0, r1, r2;
    } vec_t;

    vec_t vt [7];
    exp_t sb [$];
    exp_t mon_e, live, snap;
    int   n_chk = 0;
    int   n_err = 0;
    int   lat;

    enc_mpp #(.BPC(BPC)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_vld        (in_vld),
        .in_rdy        (in_rdy),
        .isFls         (isFls),
        .mpp_step      (mpp_step),
        .src_c0        (src_c0),
        .src_c1        (src_c1),
        .src_c2        (src_c2),
        .prev_rec_c0   (prev_rec_c0),
        .prev_rec_c1   (prev_rec_c1),
        .prev_rec_c2   (prev_rec_c2),
        .out_vld       (out_vld),
        .out_rdy       (out_rdy),
        .mpp_qres_ssm0 (ssm0),
        .mpp_qres_ssm1 (ssm1),
        .mpp_qres_ssm2 (ssm2),
        .mpp_qres_ssm3 (ssm3),
        .rec_c0        (rec_c0),
        .rec_c1        (rec_c1),
        .rec_c2        (rec_c2),
        .blkcounter    (blkcounter)
    );

    always #5 clk = ~clk;

    assign live = {ssm0, ssm1, ssm2, ssm3, rec_c0, rec_c1, rec_c2};

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t build(input vec_t v);
        exp_t e;
        logic [N-1:0][7:0] q0, q1, q2;
        int d;
        e = '0;
        for (int i = 0; i < N; i++) begin
            d = (v.ramp != 0) ? i : 0;
            q0[i]   = 8'(v.q0 + d);
            q1[i]   = 8'(v.q1 - d);
            q2[i]   = 8'(v.q2 + d);
            e.r0[i] = 8'(v.r0 + 4 * d);
            e.r1[i] = 9'(v.r1 - 4 * d);
            e.r2[i] = 9'(v.r2 + 4 * d);
        end
        for (int i = 0; i < 4; i++) begin
            e.s0[i]     = q0[i];
            e.s0[i + 4] = q1[i];
            e.s0[i + 8] = q2[i];
        end
        for (int j = 4; j < N; j++) begin
            e.s1[j - 4] = q0[j];
            e.s2[j - 4] = q1[j];
            e.s3[j - 4] = q2[j];
        end
        return e;
    endfunction

    task automatic send(input vec_t v);
        int w;
        int d;
        isFls    = (v.fls != 0);
        mpp_step = 4'(v.step);
        for (int i = 0; i < N; i++) begin
            d = (v.ramp != 0) ? i : 0;
            src_c0[i]      = 8'(v.s0 + 4 * d);
            src_c1[i]      = 9'(v.s1 - 4 * d);
            src_c2[i]      = 9'(v.s2 + 4 * d);
            prev_rec_c0[i] = 8'(v.p0);
            prev_rec_c1[i] = 9'(v.p1);
            prev_rec_c2[i] = 9'(v.p2);
        end
        in_vld = 1'b1;
        w = 0;
        @(negedge clk);
        while (!in_rdy && w < 50) begin
            w++;
            @(negedge clk);
        end
        n_chk++;
        if (!in_rdy) begin
            n_err++;
            $display("FAIL send_timeout: in_rdy got 0, expected 1 within 50 cycles");
        end else begin
            sb.push_back(build(v));
        end
        @(posedge clk);
        #1;
        in_vld = 1'b0;
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 200) begin
            w++;
            @(negedge clk);
        end
        check("drain", 256'(sb.size()), 256'(0));
    endtask

    // Monitor: compares every transferred output against the oldest expected block.
    always @(negedge clk) begin
        if (!rst && out_vld) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL unexpected_out: got out_vld=1, expected no pending block");
            end else if (out_rdy) begin
                mon_e = sb.pop_front();
                check("ssm0",   256'(ssm0),   256'(mon_e.s0));
                check("ssm1",   256'(ssm1),   256'(mon_e.s1));
                check("ssm2",   256'(ssm2),   256'(mon_e.s2));
                check("ssm3",   256'(ssm3),   256'(mon_e.s3));
                check("rec_c0", 256'(rec_c0), 256'(mon_e.r0));
                check("rec_c1", 256'(rec_c1), 256'(mon_e.r1));
                check("rec_c2", 256'(rec_c2), 256'(mon_e.r2));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        //            ramp fls step  s0    s1    s2    p0   p1  p2   q0  q1   q2   r0   r1    r2
        vt[0] = '{0, 1, 2,   200,    0,    0,   0,  0,  0,  18,   0,   0, 200,    0,    0};
        vt[1] = '{0, 1, 3,     0,  -20,   37,   0,  0,  0, -16,  -3,   5,   0,  -24,   40};
        vt[2] = '{0, 1, 0,   255, -256,  255,   0,  0,  0, 127,-128, 127, 255, -128,  127};
        vt[3] = '{0, 0, 1,   100,   -3,   61, 100, -3, 50,   0,   0,   6, 100,   -3,   62};
        vt[4] = '{1, 1, 2,   128,    0,   64,   0,  0,  0,   0,   0,  16, 128,    0,   64};
        vt[5] = '{0, 1, 4,   255,  255, -256,   0,  0,  0,   7,  15, -16, 240,  240, -256};
        vt[6] = '{0, 1, 12,    0,  200, -200,   0,  0,  0,  -1,   0,  -1,   0,    0, -256};

        rst = 1'b1;
        in_vld = 1'b0;
        out_rdy = 1'b1;
        isFls = 1'b0;
        mpp_step = '0;
        src_c0 = '0;
        src_c1 = '0;
        src_c2 = '0;
        prev_rec_c0 = '0;
        prev_rec_c1 = '0;
        prev_rec_c2 = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_vld", 256'(out_vld), 256'(0));
        check("rst_blkcnt",  256'(blkcounter), 256'(0));
        check("rst_ssm0",    256'(ssm0), 256'(0));
        check("rst_rec_c1",  256'(rec_c1), 256'(0));
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_rdy", 256'(in_rdy), 256'(1));
        @(posedge clk);
        #1;

        // Four back-to-back blocks with a 5-cycle output stall starting at cycle 4.
        fork
            begin
                for (int b = 0; b < 4; b++) send(vt[b]);
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                out_rdy = 1'b0;
                @(negedge clk);
                snap = live;
                for (int c = 0; c < 5; c++) begin
                    if (c > 0) @(negedge clk);
                    check("stall_in_rdy",  256'(in_rdy), 256'(0));
                    check("stall_out_vld", 256'(out_vld), 256'(1));
                    n_chk++;
                    if (live !== snap) begin
                        n_err++;
                        $display("FAIL stall_hold: ssm1 got %h, expected held %h", live.s1, snap.s1);
                    end
                end
                @(posedge clk);
                #1;
                out_rdy = 1'b1;
            end
        join
        wait_drain();
        check("blkcnt_after_stall", 256'(blkcounter), 256'(4));

        // Single block latency.
        @(posedge clk);
        #1;
        send(vt[0]);
        lat = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            lat++;
            if (out_vld) break;
        end
        check("latency", 256'(lat), 256'(3));
        wait_drain();

        // Remaining vectors streamed at full rate.
        @(posedge clk);
        #1;
        for (int b = 1; b < 7; b++) send(vt[b]);
        wait_drain();
        check("blkcnt_stream", 256'(blkcounter), 256'(11));

        // Reset with two blocks in flight.
        @(posedge clk);
        #1;
        send(vt[5]);
        send(vt[6]);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        check("mid_rst_out_vld", 256'(out_vld), 256'(0));
        check("mid_rst_blkcnt",  256'(blkcounter), 256'(0));
        check("mid_rst_ssm1",    256'(ssm1), 256'(0));
        check("mid_rst_rec_c2",  256'(rec_c2), 256'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_rdy", 256'(in_rdy), 256'(1));
        repeat (6) @(negedge clk);
        check("post_rst_no_out", 256'(out_vld), 256'(0));
        @(posedge clk);
        #1;
        send(vt[2]);
        wait_drain();
        check("post_rst_blkcnt", 256'(blkcounter), 256'(1));

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
